mem_stage: RTL

MEM pipeline stage: consumes the EX-stage outputs (ALU result, store data, destination register, MEM/WB control), performs the data-memory load/store against an internal word-addressed RAM with a configurable access latency, and drives the MEM/WB pipeline register toward write-back. While a memory access is in flight it stalls upstream. The EX/MEM register holds its contents for as long as Out_Stall is high.

---
 rtl/mem_stage.sv | 113 +++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage with multi-cycle data RAM access and upstream stall
module mem_stage #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] In_Result,
    input  logic [31:0] In_Data,
    input  logic [4:0]  In_Rd,
    input  logic [1:0]  In_MEMControl,
    input  logic [1:0]  In_WBControl,
    input  logic        In_Valid,
    output logic        Out_Stall,
    output logic [31:0] Out_ReadData,
    output logic [31:0] Out_ALUResult,
    output logic [4:0]  Out_Rd,
    output logic [1:0]  Out_WBControl,
    output logic        Out_Valid
);
    localparam int         AW     = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;

    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [4:0]  rd_lat_q;
    logic [1:0]  mctl_q;
    logic [1:0]  wb_lat_q;

    logic [31:0] rdata_q;
    logic [31:0] alu_q;
    logic [4:0]  rd_q;
    logic [1:0]  wb_q;
    logic        valid_q;

    logic [31:0] ram_q [DEPTH];
    logic [AW-1:0] idx;
    logic [31:0]   ram_rd;
    logic          done;
    logic          ram_we;

    // Byte address to word index; low two bits and bits above the RAM range are dropped.
    assign idx    = addr_q[AW+1:2];
    assign ram_rd = ram_q[idx];
    assign done   = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign ram_we = done && mctl_q[1] && !Rst;

    always_ff @(posedge Clk) begin
        if (ram_we) begin
            ram_q[idx] <= data_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= 32'd0;
            data_q   <= 32'd0;
            rd_lat_q <= 5'd0;
            mctl_q   <= 2'b00;
            wb_lat_q <= 2'b00;
            rdata_q  <= 32'd0;
            alu_q    <= 32'd0;
            rd_q     <= 5'd0;
            wb_q     <= 2'b00;
            valid_q  <= 1'b0;
        end else if (state_q == IDLE) begin
            if (!In_Valid) begin
                valid_q <= 1'b0;
                wb_q    <= 2'b00;
            end else if (In_MEMControl != 2'b00) begin
                addr_q   <= In_Result;
                data_q   <= In_Data;
                rd_lat_q <= In_Rd;
                mctl_q   <= In_MEMControl;
                wb_lat_q <= In_WBControl;
                cnt_q    <= LAT_M1;
                state_q  <= ACCESS;
                valid_q  <= 1'b0;
                wb_q     <= 2'b00;
            end else begin
                alu_q   <= In_Result;
                rd_q    <= In_Rd;
                wb_q    <= In_WBControl;
                rdata_q <= 32'd0;
                valid_q <= 1'b1;
            end
        end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end else begin
            // ram_rd is sampled before this edge's write lands, giving read-before-write.
            rdata_q <= mctl_q[0] ? ram_rd : 32'd0;
            alu_q   <= addr_q;
            rd_q    <= rd_lat_q;
            wb_q    <= wb_lat_q;
            valid_q <= 1'b1;
            state_q <= IDLE;
        end
    end

    assign Out_Stall     = (state_q == ACCESS);
    assign Out_ReadData  = rdata_q;
    assign Out_ALUResult = alu_q;
    assign Out_Rd        = rd_q;
    assign Out_WBControl = wb_q;
    assign Out_Valid     = valid_q;
endmodule
